costas_pi_filter: RTL and testbench
===================================

# costas_pi_filter

Parametrised proportional-integral loop filter for the Costas carrier loop, replacing the fixed truncating filter. Takes one signed phase-error sample per integrate-and-dump epoch from the phase discriminator and produces a saturated signed frequency correction word for the carrier NCO. An internal lock detector switches between wide acquisition gains and narrow tracking gains.

## Interface
- ERR_W, 28, phase-error width (signed)
- INT_W, 40, integrator width; requires INT_W >= OUT_W >= ERR_W
- OUT_W, 32, NCO correction width (signed)
- KP_SHIFT_ACQ / KI_SHIFT_ACQ, 4 / 10, proportional / integral right-shifts in ACQUIRE
- KP_SHIFT_TRK / KI_SHIFT_TRK, 8 / 16, proportional / integral right-shifts in TRACK
- LOCK_THRESH, 2**20, absolute-error threshold for the lock detector
- LOCK_CNT, 16, consecutive small-error epochs needed to enter TRACK
- LOSS_CNT, 4, consecutive large-error epochs needed to return to ACQUIRE
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- err_valid  in  1  one-cycle strobe qualifying phase_error
- phase_error  in  ERR_W  signed phase error
- hold  in  1  freeze integrator (coast)
- clear  in  1  synchronous soft clear
- nco_valid  out  1  one-cycle strobe qualifying nco_correction
- nco_correction  out  OUT_W  signed correction, held between strobes
- err_sign  out  1  sign bit of the last accepted phase_error
- locked  out  1  high while in TRACK

## Operation
- Reset (rst low at a clock edge): nco_correction=0, nco_valid=0, err_sign=0, locked=0, integrator=0, both counters=0, state=ACQUIRE, pipeline valids=0.
- Stage 1 (cycle of err_valid): register prop = phase_error >>> KP_SHIFT_x and inc = phase_error >>> KI_SHIFT_x (arithmetic, sign-extended to INT_W+1), where x = the state before this edge; register err_sign.
- Stage 2: integ_next = sat_INT_W(integ + inc), or integ unchanged if hold=1 in this cycle; nco_correction = sat_OUT_W(prop + integ_next), computed in INT_W+1 bits; nco_valid pulses.
- Saturation clamps to [-2^(W-1), 2^(W-1)-1]; no wrap-around anywhere.
- Lock detector, evaluated on each err_valid using the raw input; |e| computed in ERR_W+1 bits so |-2^(ERR_W-1)| = 2^(ERR_W-1).
- ACQUIRE: |e| < LOCK_THRESH increments lock_cnt, else lock_cnt=0. When lock_cnt reaches LOCK_CNT: state=TRACK, counters cleared.
- TRACK: |e| >= LOCK_THRESH increments loss_cnt, else loss_cnt=0. When loss_cnt reaches LOSS_CNT: state=ACQUIRE, counters cleared.
- The integrator is not rescaled on a gain switch.
- clear=1: same effect as reset, except nco_correction keeps its last value. An err_valid in the same cycle is dropped. rst has priority over clear.
- hold does not affect the lock detector or the proportional path.

## Timing
- Latency: err_valid at edge t gives nco_valid at edge t+2.
- Throughput: one sample per cycle; back-to-back err_valid is legal.
- locked is registered and reflects a state change one cycle after the deciding err_valid.
- The sample that triggers a transition uses the old gains; the next sample uses the new gains.
- clear or rst during samples in flight kills both pipeline stages; no nco_valid is produced for them.

## Structure
- Package costas_pkg holds the state typedef (ACQUIRE, TRACK) and the saturating add/clamp function, parametrised by width.
- Sub-module costas_lock_detect contains the state, the two counters and locked. It takes err_valid, |e| and clear, and outputs the state to the filter datapath.

## Test plan
- Defaults, a single err_valid with phase_error=65536 → nco_valid 2 cycles later, nco_correction=4160 (4096+64); a second identical sample → 4224.
- phase_error=-65536 once → nco_correction=-4160, err_sign=1. The most-negative input -2^27 must not overflow: nco_correction=-(2^23+2^17).
- 16 samples of 100 → locked rises the cycle after the 16th. 17th sample of 65536 → proportional term 256, integrator increment 1. 4 samples of 2^21 → locked falls.
- hold=1 during 3 samples of 65536 after one prior sample → the integrator stays at 64, every output = 4096+64.
- INT_W=32, OUT_W=28, phase_error=2^27-1 repeated 20000 times → integrator clamps at 2^31-1, nco_correction clamps at 2^27-1 with no wrap. Then clear → integrator 0, locked 0.
- rst asserted one cycle after an err_valid → no nco_valid follows; all outputs at their reset values.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared types and helpers for the Costas PI loop filter.
package costas_pkg;

    // Loop-filter operating mode: wide gains while acquiring, narrow gains once locked.
    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } costas_state_e;

    // Working width for the clamp helper; callers never pass more than 41 bits.
    localparam int SAT_W = 64;

    // Clamp a signed value into the representable range of a w-bit signed word.
    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input logic signed [SAT_W-1:0] x,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            sat_clamp = hi;
        end else if (x < lo) begin
            sat_clamp = lo;
        end else begin
            sat_clamp = x;
        end
    endfunction

    // Saturating signed add; both operands must already be sign-extended to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        sat_add = sat_clamp(a + b, w);
    endfunction

endpackage

// File: rtl/costas_lock_detect.sv
// Lock detector: counts consecutive small/large error epochs and selects the gain set.
module costas_lock_detect
    import costas_pkg::*;
#(
    parameter int ABS_W       = 29,
    parameter int LOCK_THRESH = 2**20,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_CNT    = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_err_valid,
    input  logic [ABS_W-1:0]  i_err_abs,
    output costas_state_e     o_state,
    output logic              o_locked
);

    localparam int CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ABS_W-1:0] THRESH    = ABS_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CNT - 1);

    costas_state_e    r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] r_loss_cnt;
    logic             r_locked;
    logic             w_small;

    assign w_small  = (i_err_abs < THRESH);
    assign o_state  = r_state;
    assign o_locked = r_locked;

    // Mode state machine with its two run-length counters; locked mirrors the next state.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_state    <= ACQUIRE;
            r_lock_cnt <= '0;
            r_loss_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (i_err_valid) begin
            case (r_state)
                ACQUIRE: begin
                    if (!w_small) begin
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        r_state    <= TRACK;
                        r_locked   <= 1'b1;
                        r_lock_cnt <= '0;
                        r_loss_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (w_small) begin
                        r_loss_cnt <= '0;
                    end else if (r_loss_cnt == LOSS_LAST) begin
                        r_state    <= ACQUIRE;
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                        r_loss_cnt <= '0;
                    end else begin
                        r_loss_cnt <= r_loss_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ACQUIRE;
                    r_locked   <= 1'b0;
                    r_lock_cnt <= '0;
                    r_loss_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/costas_pi_filter.sv
// Two-stage PI loop filter for the Costas carrier loop with lock-dependent gains.
module costas_pi_filter
    import costas_pkg::*;
#(
    parameter int ERR_W        = 28,
    parameter int INT_W        = 40,
    parameter int OUT_W        = 32,
    parameter int KP_SHIFT_ACQ = 4,
    parameter int KI_SHIFT_ACQ = 10,
    parameter int KP_SHIFT_TRK = 8,
    parameter int KI_SHIFT_TRK = 16,
    parameter int LOCK_THRESH  = 2**20,
    parameter int LOCK_CNT     = 16,
    parameter int LOSS_CNT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    err_valid,
    input  logic signed [ERR_W-1:0] phase_error,
    input  logic                    hold,
    input  logic                    clear,
    output logic                    nco_valid,
    output logic signed [OUT_W-1:0] nco_correction,
    output logic                    err_sign,
    output logic                    locked
);

    localparam int S_W   = INT_W + 1;
    localparam int ABS_W = ERR_W + 1;

    costas_state_e           w_state;
    logic signed [S_W-1:0]   w_err_wide;
    logic signed [ABS_W-1:0] w_err_ext;
    logic [ABS_W-1:0]        w_err_abs;
    logic signed [S_W-1:0]   w_prop;
    logic signed [S_W-1:0]   w_inc;
    logic signed [INT_W-1:0] w_integ_next;
    logic signed [OUT_W-1:0] w_out;

    logic                    r_v1;
    logic signed [S_W-1:0]   r_prop;
    logic signed [S_W-1:0]   r_inc;
    logic                    r_err_sign;
    logic signed [INT_W-1:0] r_integ;
    logic signed [OUT_W-1:0] r_nco;
    logic                    r_nco_valid;

    // |e| is one bit wider than the input so the most-negative code has a true magnitude.
    assign w_err_wide = S_W'(phase_error);
    assign w_err_ext  = ABS_W'(phase_error);
    assign w_err_abs  = w_err_ext[ABS_W-1] ? -w_err_ext : w_err_ext;

    costas_lock_detect #(
        .ABS_W       (ABS_W),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_CNT    (LOCK_CNT),
        .LOSS_CNT    (LOSS_CNT)
    ) u_lock (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_clear     (clear),
        .i_err_valid (err_valid),
        .i_err_abs   (w_err_abs),
        .o_state     (w_state),
        .o_locked    (locked)
    );

    // Gain selection uses the mode in force before this edge.
    always_comb begin
        w_prop = w_err_wide >>> KP_SHIFT_ACQ;
        w_inc  = w_err_wide >>> KI_SHIFT_ACQ;
        case (w_state)
            TRACK: begin
                w_prop = w_err_wide >>> KP_SHIFT_TRK;
                w_inc  = w_err_wide >>> KI_SHIFT_TRK;
            end
            ACQUIRE: begin
                w_prop = w_err_wide >>> KP_SHIFT_ACQ;
                w_inc  = w_err_wide >>> KI_SHIFT_ACQ;
            end
            default: begin
                w_prop = w_err_wide >>> KP_SHIFT_ACQ;
                w_inc  = w_err_wide >>> KI_SHIFT_ACQ;
            end
        endcase
    end

    // Stage 1: capture the scaled proportional and integral terms.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_v1       <= 1'b0;
            r_prop     <= '0;
            r_inc      <= '0;
            r_err_sign <= 1'b0;
        end else begin
            r_v1 <= err_valid;
            if (err_valid) begin
                r_prop     <= w_prop;
                r_inc      <= w_inc;
                r_err_sign <= phase_error[ERR_W-1];
            end
        end
    end

    // Stage 2 arithmetic: saturating integrate (frozen while coasting) plus proportional term.
    always_comb begin
        w_integ_next = r_integ;
        if (hold) begin
            w_integ_next = r_integ;
        end else begin
            w_integ_next = INT_W'(sat_add(SAT_W'(r_integ), SAT_W'(r_inc), INT_W));
        end
        w_out = OUT_W'(sat_add(SAT_W'(r_prop), SAT_W'(w_integ_next), OUT_W));
    end

    // Stage 2 registers; a soft clear keeps the last correction so the NCO does not jump.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_integ     <= '0;
            r_nco       <= '0;
            r_nco_valid <= 1'b0;
        end else if (clear) begin
            r_integ     <= '0;
            r_nco_valid <= 1'b0;
        end else begin
            r_nco_valid <= r_v1;
            if (r_v1) begin
                r_integ <= w_integ_next;
                r_nco   <= w_out;
            end
        end
    end

    assign nco_valid      = r_nco_valid;
    assign nco_correction = r_nco;
    assign err_sign       = r_err_sign;

endmodule

// File: tb/tb_costas_pi_filter.sv
// Self-checking bench for costas_pi_filter: golden model feeds a scoreboard of corrections.
module tb_costas_pi_filter;

    logic clk = 1'b0;
    logic rst;
    logic err_valid, hold, clear;
    logic signed [27:0] phase_error;
    logic nco_valid, err_sign, locked;
    logic signed [31:0] nco_correction;

    // Small-integrator instance for the saturation scenario.
    logic s_err_valid, s_hold, s_clear;
    logic signed [27:0] s_phase_error;
    logic s_nco_valid, s_err_sign, s_locked;
    logic signed [27:0] s_nco_correction;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic signed [31:0] exp_q[$];
    longint m_integ;
    bit     m_track;
    int     m_lock, m_loss;
    logic signed [31:0] m_last;

    int     s_pulses = 0;
    bit     s_wrap = 1'b0;
    longint s_prev = 0;

    always #5 clk = ~clk;

    costas_pi_filter dut (
        .clk(clk), .rst(rst), .err_valid(err_valid), .phase_error(phase_error),
        .hold(hold), .clear(clear), .nco_valid(nco_valid),
        .nco_correction(nco_correction), .err_sign(err_sign), .locked(locked)
    );

    costas_pi_filter #(.ERR_W(28), .INT_W(32), .OUT_W(28)) dut_s (
        .clk(clk), .rst(rst), .err_valid(s_err_valid), .phase_error(s_phase_error),
        .hold(s_hold), .clear(s_clear), .nco_valid(s_nco_valid),
        .nco_correction(s_nco_correction), .err_sign(s_err_sign), .locked(s_locked)
    );

    function automatic longint msat(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        m_integ = 0; m_track = 1'b0; m_lock = 0; m_loss = 0;
    endtask

    task automatic model_push(input longint e);
        longint prop, inc, a;
        prop = m_track ? (e >>> 8)  : (e >>> 4);
        inc  = m_track ? (e >>> 16) : (e >>> 10);
        if (!hold) m_integ = msat(m_integ + inc, 40);
        m_last = 32'(msat(prop + m_integ, 32));
        exp_q.push_back(m_last);
        a = (e < 0) ? -e : e;
        if (!m_track) begin
            if (a < (longint'(1) << 20)) begin
                m_lock++;
                if (m_lock == 16) begin m_track = 1'b1; m_lock = 0; m_loss = 0; end
            end else m_lock = 0;
        end else begin
            if (a >= (longint'(1) << 20)) begin
                m_loss++;
                if (m_loss == 4) begin m_track = 1'b0; m_lock = 0; m_loss = 0; end
            end else m_loss = 0;
        end
    endtask

    // Scoreboard: every correction strobe must match the oldest expected value.
    always @(negedge clk) begin
        if (rst && nco_valid) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_nco_valid: got correction %0d, required no strobe", nco_correction);
            end else begin
                logic signed [31:0] exp_v;
                exp_v = exp_q.pop_front();
                if (nco_correction !== exp_v)
                    $display("FAIL nco_correction: got %0d, required %0d", nco_correction, exp_v);
                else pass_cnt++;
            end
        end
    end

    // Watch the small instance for any downward step (wrap-around) while it integrates.
    always @(negedge clk) begin
        if (rst && s_nco_valid) begin
            s_pulses++;
            if (longint'(s_nco_correction) < s_prev) s_wrap = 1'b1;
            s_prev = longint'(s_nco_correction);
        end
    end

    task automatic send(input longint e);
        phase_error = 28'(e);
        err_valid = 1'b1;
        model_push(e);
        @(negedge clk);
        err_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic flush();
        int n = 0;
        while (exp_q.size() != 0 && n < 8) begin @(negedge clk); n++; end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL flush_timeout: %0d results still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({nco_valid, err_sign, locked} !== 3'b000 || nco_correction !== 32'sd0)
            $display("FAIL reset_outputs: got v=%b s=%b l=%b c=%0d, required all 0",
                     nco_valid, err_sign, locked, nco_correction);
        else pass_cnt++;
        total_cnt++;
        if ({s_nco_valid, s_locked} !== 2'b00 || s_nco_correction !== 28'sd0)
            $display("FAIL reset_outputs_small: got v=%b l=%b c=%0d, required all 0",
                     s_nco_valid, s_locked, s_nco_correction);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send(65536);
        total_cnt++;
        if (nco_valid !== 1'b0) $display("FAIL latency_early: nco_valid=%b one cycle after sample, required 0", nco_valid);
        else pass_cnt++;
        flush();
        send(65536);
        flush();
        total_cnt++;
        if (nco_correction !== 32'sd4224 || err_sign !== 1'b0)
            $display("FAIL basic_second: got %0d sign %b, required 4224 sign 0", nco_correction, err_sign);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        do_clear();
        send(-65536);
        flush();
        total_cnt++;
        if (nco_correction !== -32'sd4160 || err_sign !== 1'b1)
            $display("FAIL negative: got %0d sign %b, required -4160 sign 1", nco_correction, err_sign);
        else pass_cnt++;
        do_clear();
        send(-(longint'(1) << 27));
        flush();
        total_cnt++;
        if (nco_correction !== -32'sd8519680)
            $display("FAIL most_negative: got %0d, required -8519680", nco_correction);
        else pass_cnt++;
    endtask

    task automatic test_lock();
        do_clear();
        for (int i = 0; i < 15; i++) send(100);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL lock_early: locked=%b after 15 samples, required 0", locked);
        else pass_cnt++;
        send(100);
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL lock_rise: locked=%b after 16 samples, required 1", locked);
        else pass_cnt++;
        send(65536);
        flush();
        total_cnt++;
        if (nco_correction !== 32'sd257) $display("FAIL track_gains: got %0d, required 257", nco_correction);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) send(longint'(1) << 21);
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL loss_early: locked=%b after 3 large samples, required 1", locked);
        else pass_cnt++;
        send(longint'(1) << 21);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL loss_fall: locked=%b after 4 large samples, required 0", locked);
        else pass_cnt++;
        flush();
    endtask

    task automatic test_hold();
        do_clear();
        send(65536);
        flush();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) send(65536);
        @(negedge clk);
        hold = 1'b0;
        flush();
        total_cnt++;
        if (nco_correction !== 32'sd4160) $display("FAIL hold_coast: got %0d, required 4160", nco_correction);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 40; i++) begin
            longint e;
            e = longint'($urandom_range(0, 32'h0080_0000)) - (longint'(1) << 22);
            send(e);
        end
        flush();
    endtask

    task automatic test_clear();
        logic signed [31:0] kept;
        do_clear();
        for (int i = 0; i < 16; i++) send(100);
        flush();
        kept = m_last;
        phase_error = 28'sd65536;
        err_valid = 1'b1;
        do_clear();
        err_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (locked !== 1'b0 || nco_correction !== kept)
            $display("FAIL clear_state: locked=%b corr=%0d, required 0 and %0d", locked, nco_correction, kept);
        else pass_cnt++;
        send(65536);
        flush();
    endtask

    task automatic test_rst_inflight();
        int seen = 0;
        phase_error = 28'sd65536;
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            if (nco_valid) seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (seen != 0 || nco_correction !== 32'sd0 || err_sign !== 1'b0 || locked !== 1'b0)
            $display("FAIL rst_inflight: strobes=%0d corr=%0d sign=%b locked=%b, required 0/0/0/0",
                     seen, nco_correction, err_sign, locked);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int n = 0;
        s_phase_error = 28'sh7FF_FFFF;
        s_err_valid = 1'b1;
        repeat (20000) @(negedge clk);
        s_err_valid = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (s_pulses != 20000) $display("FAIL sat_count: got %0d strobes, required 20000", s_pulses);
        else pass_cnt++;
        total_cnt++;
        if (s_wrap || s_nco_correction !== 28'sh7FF_FFFF)
            $display("FAIL sat_clamp: wrap=%b corr=%0d, required wrap 0 corr 134217727", s_wrap, s_nco_correction);
        else pass_cnt++;
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        total_cnt++;
        if (s_locked !== 1'b0 || s_nco_correction !== 28'sh7FF_FFFF)
            $display("FAIL sat_clear: locked=%b corr=%0d, required 0 and 134217727", s_locked, s_nco_correction);
        else pass_cnt++;
        s_phase_error = 28'sd65536;
        s_err_valid = 1'b1;
        @(negedge clk);
        s_err_valid = 1'b0;
        while (!s_nco_valid && n < 6) begin @(negedge clk); n++; end
        total_cnt++;
        if (!s_nco_valid || s_nco_correction !== 28'sd4160)
            $display("FAIL sat_after_clear: valid=%b corr=%0d, required 1 and 4160", s_nco_valid, s_nco_correction);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; err_valid = 1'b0; hold = 1'b0; clear = 1'b0; phase_error = '0;
        s_err_valid = 1'b0; s_hold = 1'b0; s_clear = 1'b0; s_phase_error = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_negative();
        test_lock();
        test_hold();
        test_back_to_back();
        test_clear();
        test_rst_inflight();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
